// File: rtl/seven_seg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seven_seg_pkg: shared glyph table, blank pattern and scan state type.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package seven_seg_pkg;

  // Segment order {g,f,e,d,c,b,a}, active-high; element i is the glyph for hex i.
  localparam logic [0:15][6:0] GLYPH_TABLE = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_e;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/seven_seg_scanner_hex_to_seg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hex_to_seg: combinational 4-bit hex to 7-segment (active-high) decode.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = hex_glyph(i_nibble);
  end

endmodule : hex_to_seg
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seven_seg_scanner: time-multiplexed hex 7-segment display driver with     |
// | per-frame snapshot and blanking dead time. Define SEVEN_SEG_LZB_EN for    |
// | leading-zero blanking.                                                    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int CLK_HZ       = 12_000_000,
  parameter int FRAME_HZ     = 1_000,
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           value,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  frame_done
);

  localparam int DIV   = CLK_HZ / (FRAME_HZ * NUM_DIGITS);
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(BLANK_CYCLES + 2);

  // Dead-time counter parks at this value when no blanking interval is running.
  localparam logic [CNT_W-1:0]      CNT_SAT  = CNT_W'(BLANK_CYCLES);
  localparam logic [6:0]            SEG_IDLE = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  generate
    if (DIV <= BLANK_CYCLES + 1) begin : g_div_too_small
      $error("seven_seg_scanner: DIV must exceed BLANK_CYCLES+1");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("seven_seg_scanner: NUM_DIGITS must be 1..8");
    end
  endgenerate

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  scan_state_e           state_q, state_d;
  logic [31:0]           snap_q, snap_d;
  logic                  frame_done_q, frame_done_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

  logic                  tick;
  logic                  wrap;
  logic [3:0]            nibble;
  logic [6:0]            glyph;
  logic                  show;
  logic [6:0]            seg_raw;
  logic [NUM_DIGITS-1:0] sel_raw;

  hex_to_seg u_hex_to_seg (
    .i_nibble (nibble),
    .o_seg    (glyph)
  );

  always_comb begin
    tick = (presc_q == PRE_W'(DIV - 1));
    wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

    presc_d      = tick ? '0 : presc_q + 1'b1;
    idx_d        = idx_q;
    snap_d       = wrap ? value : snap_q;
    frame_done_d = wrap;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      state_d = (BLANK_CYCLES == 0) ? ON : BLANK;
      cnt_d   = (BLANK_CYCLES == 0) ? CNT_SAT : '0;
    end else if (state_q == BLANK && cnt_q != CNT_SAT) begin
      if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
        state_d = ON;
        cnt_d   = CNT_SAT;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    nibble  = '0;
    sel_raw = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nibble     = snap_q[4*i +: 4];
        sel_raw[i] = (state_q == ON);
      end
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  logic [IDX_W-1:0] top_idx;

  // Digit 0 is always shown, so an all-zero snapshot leaves top_idx at 0.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (snap_q[4*i +: 4] != 4'h0) begin
        top_idx = IDX_W'(i);
      end
    end
    show = (idx_q <= top_idx);
  end
`else
  always_comb begin
    show = 1'b1;
  end
`endif

  always_comb begin
    seg_raw = (state_q == ON && show) ? glyph : SEG_OFF;
    seg_d   = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    sel_d   = (ACTIVE_LOW != 0) ? ~sel_raw : sel_raw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q      <= '0;
      idx_q        <= IDX_W'(NUM_DIGITS - 1);
      cnt_q        <= CNT_SAT;
      state_q      <= BLANK;
      snap_q       <= '0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_IDLE;
      sel_q        <= SEL_IDLE;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      snap_q       <= snap_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
    end
  end

  assign seg        = seg_q;
  assign digit_sel  = sel_q;
  assign frame_done = frame_done_q;

endmodule : seven_seg_scanner
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// Bench for seven_seg_scanner: cycle-count model of the scan timeline plus
// literal expectations at key points of each scenario.
module tb_seven_seg_scanner;

  localparam int CLK_HZ       = 800;
  localparam int FRAME_HZ     = 10;
  localparam int NUM_DIGITS   = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int DIV          = CLK_HZ / (FRAME_HZ * NUM_DIGITS);
  localparam int FRAME_LEN    = DIV * NUM_DIGITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value = 32'h0;
  logic [6:0]  seg;
  logic [7:0]  digit_sel;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  int          n = 0;
  logic [31:0] m_snap = 32'h0;
  logic [6:0]  exp_seg = 7'h7F;
  logic [7:0]  exp_sel = 8'hFF;
  logic        exp_fd = 1'b0;

  seven_seg_scanner #(
    .CLK_HZ       (CLK_HZ),
    .FRAME_HZ     (FRAME_HZ),
    .NUM_DIGITS   (NUM_DIGITS),
    .BLANK_CYCLES (BLANK_CYCLES),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .seg        (seg),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic bit shown(input logic [31:0] snap, input int dig);
`ifdef SEVEN_SEG_LZB_EN
    int top = 0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (snap[4*i +: 4] != 4'h0) top = i;
    return dig <= top;
`else
    return 1'b1;
`endif
  endfunction

  // Outputs after rising edge n (edges counted from reset release). Slot k
  // (digit (k-1) mod N) begins on the tick at edge k*DIV; its glyph is visible
  // after edges k*DIV+BLANK+1 .. (k+1)*DIV, blank after the other BLANK edges.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n = 0;
      m_snap = 32'h0;
      exp_seg = 7'h7F;
      exp_sel = 8'hFF;
      exp_fd = 1'b0;
    end else begin
      int p, slot, r, dig;
      n = n + 1;
      exp_seg = 7'h7F;
      exp_sel = 8'hFF;
      exp_fd = 1'b0;
      if (n >= DIV + BLANK_CYCLES + 1) begin
        p = n - (BLANK_CYCLES + 1);
        slot = p / DIV;
        r = p % DIV;
        dig = (slot - 1) % NUM_DIGITS;
        if (r < DIV - BLANK_CYCLES) begin
          exp_sel = ~(8'b1 << dig);
          if (shown(m_snap, dig)) exp_seg = ~glyph(m_snap[4*dig +: 4]);
        end
      end
      if (n >= DIV && ((n - DIV) % FRAME_LEN) == 0) begin
        exp_fd = 1'b1;
        m_snap = value;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (n=%0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  always @(negedge clk) begin
    check("seg", {25'h0, seg}, {25'h0, exp_seg});
    check("digit_sel", {24'h0, digit_sel}, {24'h0, exp_sel});
    check("frame_done", {31'h0, frame_done}, {31'h0, exp_fd});
    check("one_hot", {31'h0, ($countones(~digit_sel) <= 1)}, 32'h1);
  end

  task automatic goto(input int t);
    int guard = 0;
    while (n < t && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("goto_cycle", n, t);
  endtask

  initial begin
    value = 32'h1234_5678;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_seg", {25'h0, seg}, 32'h7F);
    check("rst_sel", {24'h0, digit_sel}, 32'hFF);
    check("rst_fd", {31'h0, frame_done}, 32'h0);
    rst = 1'b1;

    // First frame after reset
    goto(10);  check("first_fd", {31'h0, frame_done}, 32'h1);
    goto(11);  check("blank1_sel", {24'h0, digit_sel}, 32'hFF);
    goto(12);  check("blank2_sel", {24'h0, digit_sel}, 32'hFF);
    goto(13);  check("d0_sel", {24'h0, digit_sel}, 32'hFE);
               check("d0_seg8", {25'h0, seg}, 32'h00);
    goto(20);  check("d0_last_sel", {24'h0, digit_sel}, 32'hFE);
    goto(21);  check("d0_off_sel", {24'h0, digit_sel}, 32'hFF);
    goto(83);  check("d7_sel", {24'h0, digit_sel}, 32'h7F);
               check("d7_seg1", {25'h0, seg}, 32'h79);
    goto(90);  check("second_fd", {31'h0, frame_done}, 32'h1);

    // Mid-frame value change must not tear the current frame
    goto(100); value = 32'hDEAD_BEEF;
    goto(123); check("d3_old_sel", {24'h0, digit_sel}, 32'hF7);
               check("d3_old_seg5", {25'h0, seg}, 32'h12);
    goto(173); check("new_d0_segF", {25'h0, seg}, 32'h0E);
    goto(183); check("new_d1_segE", {25'h0, seg}, 32'h06);

    // Leading zeros
    goto(200); value = 32'h0000_00A0;
    goto(253); check("lz_d0_seg0", {25'h0, seg}, 32'h40);
    goto(263); check("lz_d1_sel", {24'h0, digit_sel}, 32'hFD);
               check("lz_d1_segA", {25'h0, seg}, 32'h08);
    goto(273); check("lz_d2_sel", {24'h0, digit_sel}, 32'hFB);
`ifdef SEVEN_SEG_LZB_EN
               check("lz_d2_seg", {25'h0, seg}, 32'h7F);
`else
               check("lz_d2_seg", {25'h0, seg}, 32'h40);
`endif

    // Asynchronous reset while digit 4 is lit
    goto(340); value = 32'hCAFE_0123;
    goto(375); check("d4_sel", {24'h0, digit_sel}, 32'hEF);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_seg", {25'h0, seg}, 32'h7F);
    check("async_rst_sel", {24'h0, digit_sel}, 32'hFF);
    check("async_rst_fd", {31'h0, frame_done}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    goto(10);  check("restart_fd", {31'h0, frame_done}, 32'h1);
    goto(13);  check("restart_d0_sel", {24'h0, digit_sel}, 32'hFE);
               check("restart_d0_seg3", {25'h0, seg}, 32'h30);
    goto(23);  check("restart_d1_seg2", {25'h0, seg}, 32'h24);
    goto(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seven_seg_scanner
`default_nettype wire
